// File: rtl/n_bit_accumulator.sv
// n_bit_accumulator: sums a burst of LEN unsigned operands via a ripple adder.
// Ports: clk/rst_n, start+len, in_* operand stream, out_* result, ovf, busy.
module n_bit_full_adder_top #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out
);
  logic [N-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign out[i] = a[i] ^ b[i] ^ c[i];
    if (i < N - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) |
                      (c[i] & (a[i] ^ b[i]));
    end
  end
endmodule

module n_bit_accumulator #(
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             ovf,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [N-1:0]     acc;
  logic [N-1:0]     sum;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;
  logic             beat;
  logic             last;
  logic             wrap;

  n_bit_full_adder_top #(.N(N)) u_add (
    .a   (acc),
    .b   (in_data),
    .out (sum)
  );

  // No carry-out from the adder: a wrap shows as sum < acc.
  assign wrap = (sum < acc);
  assign beat = in_valid & in_ready;
  // Compare against len_q-1 so len = 2^LEN_W-1 never wraps cnt.
  assign last = (cnt == len_q - 1'b1);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = acc;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
            len_q <= len;
            state <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= sum;
            ovf_q <= ovf_q | wrap;
            cnt   <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/n_bit_accumulator.md
# n_bit_accumulator

Sequential accumulation stage built around `n_bit_full_adder_top`.
- Accepts a burst of LEN unsigned N-bit operands over a valid/ready stream.
- Feeds the running sum and each incoming operand to an internal `n_bit_full_adder_top` instance, then registers the adder output back into the accumulator.
- Presents the final sum and a sticky overflow flag on a valid/ready result port.

## Interface
- N, 32, operand/accumulator width; also the width parameter of the internal adder.
- LEN_W, 8, width of the burst-length input.

Ports:
- CLK  in  1  single clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begins a burst; sampled only in IDLE.
- LEN  in  LEN_W  number of operands in the burst; sampled with START.
- IN_VALID  in  1  operand valid.
- IN_READY  out  1  operand ready.
- IN_DATA  in  N  unsigned operand.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  result accepted by consumer.
- RESULT  out  N  accumulated sum, modulo 2^N.
- OVF  out  1  sticky: at least one addition in the burst wrapped.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE. State is registered.
- IN_READY, OUT_VALID and BUSY are decoded from state only; none depends combinationally on IN_VALID or OUT_READY.
- Adder connection: A = acc register, B = IN_DATA, sum = adder OUT. The adder has no carry-out port.
- Overflow detect: unsigned wrap when sum < acc, using full N-bit compare.
- IDLE:
  - IN_READY=0, OUT_VALID=0.
  - On START: acc←0, OVF←0, cnt←0, len_q←LEN.
  - If LEN≠0, go to ACCUM. If LEN=0, go to DONE (RESULT=0, OVF=0).
- ACCUM:
  - IN_READY=1.
  - A beat is a cycle with IN_VALID&IN_READY. On each beat: acc←sum, OVF←OVF|wrap, cnt←cnt+1.
  - When the beat is beat number len_q (cnt==len_q−1), go to DONE.
  - Cycles with IN_VALID=0 hold all state.
- DONE:
  - OUT_VALID=1. RESULT=acc and OVF are held stable.
  - When OUT_READY=1, return to IDLE. OUT_VALID drops the next cycle.
  - RESULT and OVF retain their values in IDLE until the next START.
- START is ignored in ACCUM and DONE. LEN is not re-sampled mid-burst.
- A START in the same cycle that DONE→IDLE occurs is ignored (the FSM is not yet in IDLE).
- cnt is LEN_W bits wide. LEN = 2^LEN_W−1 is the maximum burst and must not wrap cnt early.
- Reset (asynchronous, any state, including mid-burst): state=IDLE, acc=0, cnt=0, len_q=0, OVF=0. Outputs go to IN_READY=0, OUT_VALID=0, RESULT=0, OVF=0, BUSY=0. A partial burst is discarded.

## Timing
- START sampled at edge k → ACCUM (IN_READY=1) from cycle k+1. With LEN=0 → OUT_VALID=1 from cycle k+1.
- Throughput: one operand per cycle in ACCUM.
- Last beat accepted at edge m → OUT_VALID=1 and final RESULT visible from cycle m+1. Accumulate latency is 1 cycle.
- Result handshake completes at the edge where OUT_VALID&OUT_READY → IDLE next cycle. Minimum burst-to-burst gap: 1 IDLE cycle.
- Adder path is combinational acc→sum→acc. This is the single-cycle critical path; no pipelining.
- Reset deassertion: first action possible on the first rising CLK edge after RST_N goes high.

## Test plan
- N=32, LEN=3, operands 1,2,3 with IN_VALID held high → 3 consecutive beats; OUT_VALID one cycle after the third; RESULT=6, OVF=0.
- LEN=2, operands 0xFFFFFFFF,0x00000002 → RESULT=0x00000001, OVF=1. Next burst LEN=1, operand 5 → RESULT=5, OVF=0 (sticky flag cleared by START).
- LEN=0 START → OUT_VALID=1 in the following cycle; RESULT=0, OVF=0; IN_READY never asserted.
- LEN=4 with IN_VALID toggling 1,0,1,0,... and operands 10,20,30,40 → only valid beats counted; RESULT=100. Hold OUT_READY=0 for 5 cycles → OUT_VALID and RESULT stable; release → IDLE next cycle.
- RST_N pulled low after 2 of 4 beats, asynchronously between edges → all outputs 0 immediately. After release, a fresh LEN=1 burst with operand 7 → RESULT=7.
- START pulsed during ACCUM and DONE → ignored; the burst completes with the original LEN. LEN=255 burst of all 1s → RESULT=255, OVF=0, with exactly 255 beats accepted.
